// File: rtl/port_rx_buffer_if.sv
// Switch-port egress packet bus plus the downstream valid/ready handshake.
// master: the side driving packets in and consuming them; slave: the buffer.
interface port_rx_buffer_if #(
  parameter int DATA_W = 8,
  parameter int SRC_W  = 4
);
  logic              sw_valid;
  logic [SRC_W-1:0]  sw_source;
  logic [DATA_W-1:0] sw_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [SRC_W-1:0]  rx_source;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output sw_valid, sw_source, sw_data, rx_ready,
    input  rx_valid, rx_source, rx_data
  );

  modport slave (
    input  sw_valid, sw_source, sw_data, rx_ready,
    output rx_valid, rx_source, rx_data
  );
endinterface

// File: rtl/port_rx_buffer.sv
// Per-port egress receiver: first-word-fall-through FIFO with drop/error flagging.
// Optional per-source accepted-packet counters are built when PORT_RX_STATS_EN is defined.
module port_rx_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int SRC_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  port_rx_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   drop_pulse,
  output logic                   err_pulse,
  output logic                   overflow_sticky,
  input  logic                   clr_stats,
  input  logic [1:0]             stat_sel,
  output logic [15:0]            stat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [SRC_W-1:0]  src_mem  [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic src_onehot;
  logic rd_fire;
  logic slot_free;
  logic wr_fire;
  logic drop_now;
  logic err_now;

  // A full FIFO still has room when the head leaves on the same edge.
  always_comb begin
    src_onehot    = $onehot(bus.sw_source);
    bus.rx_valid  = (count != '0);
    full          = (count == DEPTH_C);
    rd_fire       = bus.rx_valid && bus.rx_ready;
    slot_free     = !full || rd_fire;
    err_now       = bus.sw_valid && !src_onehot;
    wr_fire       = bus.sw_valid && src_onehot && slot_free;
    drop_now      = bus.sw_valid && src_onehot && !slot_free;
    bus.rx_data   = bus.rx_valid ? data_mem[rd_ptr] : '0;
    bus.rx_source = bus.rx_valid ? src_mem[rd_ptr]  : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      data_mem[wr_ptr] <= bus.sw_data;
      src_mem[wr_ptr]  <= bus.sw_source;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire && !rd_fire)      count <= count + 1'b1;
      else if (!wr_fire && rd_fire) count <= count - 1'b1;
    end
  end

  // Clear beats a coincident drop so software never sees a stale overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse      <= 1'b0;
      err_pulse       <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      drop_pulse <= drop_now;
      err_pulse  <= err_now;
      if (clr_stats)     overflow_sticky <= 1'b0;
      else if (drop_now) overflow_sticky <= 1'b1;
    end
  end

`ifdef PORT_RX_STATS_EN
  logic [15:0] stat_cnt [SRC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SRC_W; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SRC_W; i++) begin
        if (clr_stats)
          stat_cnt[i] <= '0;
        else if (wr_fire && bus.sw_source[i] && (stat_cnt[i] != 16'hFFFF))
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < SRC_W; i++) begin
      if (int'(stat_sel) == i) stat_count = stat_cnt[i];
    end
  end
`else
  logic stat_sel_unused;

  assign stat_sel_unused = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: doc/port_rx_buffer.md
# port_rx_buffer

Egress-side receiver for one switch port: captures packets the `switch_4port` presents on a port's output side (`valid_out`/`source_out`/`data_out`) and buffers them in a FIFO. It presents them to a downstream consumer with a valid/ready handshake. One instance sits behind each of port0–port3. It is the receiving end of the per-port packet protocol the switch drives; the switch has no backpressure, so overflow is detected, dropped and flagged.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `DATA_W`, 8, payload width
- `SRC_W`, 4, one-hot source field width (one bit per switch port)

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `sw_valid`  in  1  packet strobe from switch port `valid_out`; one cycle per packet
- `sw_source`  in  SRC_W  one-hot source from switch port
- `sw_data`  in  DATA_W  payload from switch port
- `rx_valid`  out  1  head-of-FIFO packet available
- `rx_ready`  in  1  consumer accepts the head packet
- `rx_source`  out  SRC_W  head packet source
- `rx_data`  out  DATA_W  head packet payload
- `count`  out  $clog2(DEPTH)+1  occupancy
- `full`  out  1  count == DEPTH
- `drop_pulse`  out  1  one-cycle pulse: a packet was lost to overflow
- `err_pulse`  out  1  one-cycle pulse: a packet was rejected for a non-one-hot source
- `overflow_sticky`  out  1  set on any drop; cleared only by `clr_stats` or reset
- `clr_stats`  in  1  synchronous clear of sticky flag and counters
- `stat_sel`  in  2  source index for `stat_count` (PORT_RX_STATS_EN only)
- `stat_count`  out  16  accepted-packet count for source `stat_sel` (PORT_RX_STATS_EN only)

## Operation
- Write: on a rising edge with `sw_valid`=1, the packet is written when `sw_source` is one-hot and a slot is free.
  - A slot is free when `full`=0.
  - A slot is also free when `full`=1 and a read handshake (`rx_valid && rx_ready`) happens on the same edge. The write is accepted; `count` stays at DEPTH.
- Drop: `sw_valid`=1 with no slot free. The packet is discarded, `drop_pulse`=1 for the next cycle, and `overflow_sticky` is set.
- Error: `sw_valid`=1 with `sw_source` of zero or more than one bit set. The packet is discarded, `err_pulse`=1 for the next cycle, and it is not counted as a drop. Error check takes priority over the full check.
- Read: first-word-fall-through.
  - `rx_valid` = (count != 0); `rx_source`/`rx_data` show the head entry.
  - The head is popped on an edge with `rx_valid && rx_ready`.
  - `rx_ready` while empty has no effect.
- Pointers: read and write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. `count` is updated by +1 (write only), −1 (read only), or unchanged (both or neither).
- Ordering: strict arrival order; no reordering across sources.
- `clr_stats`: clears `overflow_sticky` and all stat counters on the next edge. If it coincides with a drop, clear wins and sticky ends at 0. FIFO contents are not affected.

## Timing
- Reset (async assert, sync release): pointers=0, `count`=0, `rx_valid`=0, `full`=0, `drop_pulse`=0, `err_pulse`=0, `overflow_sticky`=0, `stat_count` counters=0.
- `rx_source`/`rx_data` read 0 while empty after reset.
- Latency: packet sampled at edge N; `rx_valid`=1 and data visible from edge N until popped.
- Throughput: one write and one read per cycle sustained.
- Pulses: `drop_pulse` and `err_pulse` are registered, asserted exactly one cycle after the offending edge. Back-to-back offences hold them high on consecutive cycles.
- Reset mid-operation: all buffered packets are lost and outputs go to reset values immediately.

## Configuration
- `PORT_RX_STATS_EN` defined:
  - four 16-bit saturating counters, one per source bit, each incremented on every accepted write from that source;
  - `stat_count` = counter[`stat_sel`], combinational mux;
  - saturation at 16'hFFFF, no wrap;
  - `clr_stats` concurrent with an accepted write leaves that counter at 0.
- Not defined: counters are not built, `stat_count` is tied to 0, and `stat_sel` is ignored. All other behaviour is identical.

## Test plan
- Single packet: reset, `rx_ready`=0; `sw_valid` with source 4'b0001, data 8'hA0 → `rx_valid`=1 next cycle, `rx_data`=A0, `rx_source`=0001, `count`=1; `rx_ready`=1 for one cycle → `count`=0, `rx_valid`=0.
- Order and wrap: write 8'h00..8'h0B (12 packets) while reading one every other cycle, DEPTH=8 → read sequence exactly 00..0B, no `drop_pulse`, pointers wrap cleanly.
- Overflow: `rx_ready`=0, 9 consecutive writes 8'h10..8'h18 → `full`=1 after 8, `drop_pulse` one cycle after the 9th write, `overflow_sticky`=1, head still 8'h10; `clr_stats` → sticky 0.
- Full with simultaneous read/write: FIFO full, `rx_ready`=1 and write 8'h55 on the same edge → no drop, `count` stays 8, 8'h55 is the last entry read.
- Bad source: `sw_source`=4'b0000, then 4'b1100 → two `err_pulse` cycles, `count` unchanged, no `drop_pulse`.
- Stats (with `PORT_RX_STATS_EN`): 3 packets from 0010 and 1 from 1000 → `stat_sel`=1 gives 3, `stat_sel`=3 gives 1; `clr_stats` → all 0.
